// File: rtl/st_packet_generator_if.sv
// rtl/st_packet_generator_if.sv - Avalon-ST source bundle (256-bit data, 4-bit channel).
interface st_packet_generator_if;
  logic [3:0]   channel;
  logic [255:0] data;
  logic         startofpacket;
  logic         endofpacket;
  logic         valid;
  logic         ready;
  logic [4:0]   empty;

  modport master (
    output channel, data, startofpacket, endofpacket, valid, empty,
    input  ready
  );

  modport slave (
    input  channel, data, startofpacket, endofpacket, valid, empty,
    output ready
  );
endinterface

// File: rtl/st_packet_generator.sv
// rtl/st_packet_generator.sv - fixed-length test-frame source: 32-bit seq header then byte-index pattern.
// Optional inter-packet gap of IDLE_CYCLES enabled by ST_PACKET_GENERATOR_IDLE_GAP_EN.
module st_packet_generator #(
  parameter int CHANNEL     = 0,
  parameter int PKT_BYTES   = 100,
  parameter int IDLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  st_packet_generator_if.master st_out
);
  localparam int             NBEATS = (PKT_BYTES + 31) / 32;
  localparam int             BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0]  LAST   = BW'(NBEATS - 1);
  localparam logic [4:0]     EMPTY  = 5'(NBEATS * 32 - PKT_BYTES);

  if (PKT_BYTES < 4 || PKT_BYTES > 2048 || IDLE_CYCLES < 0) begin : g_bad_param
    $error("st_packet_generator: illegal PKT_BYTES or IDLE_CYCLES");
  end

  logic [31:0]   r_seq;
  logic [BW-1:0] r_beat;
  logic          r_valid;
  logic          r_sop;
  logic          r_eop;
  logic [255:0]  r_data;
  logic [4:0]    r_empty;
`ifdef ST_PACKET_GENERATOR_IDLE_GAP_EN
  logic [15:0]   r_gap;
`endif

  logic          w_xfer;
  logic          w_last;
  logic [31:0]   w_pos_seq;
  logic [BW-1:0] w_pos_beat;
  logic          w_pos_eop;

  // r_seq/r_beat always name the beat that is (or will next be) presented.
  assign w_xfer     = r_valid && st_out.ready;
  assign w_last     = (r_beat == LAST);
  assign w_pos_seq  = (w_xfer && w_last) ? r_seq + 32'd1 : r_seq;
  assign w_pos_beat = w_xfer ? (w_last ? '0 : r_beat + BW'(1)) : r_beat;
  assign w_pos_eop  = (w_pos_beat == LAST);

  function automatic logic [255:0] beat_data(input logic [31:0] seq, input logic [BW-1:0] beat);
    logic [255:0] d;
    int           idx;
    d = '0;
    for (int j = 0; j < 32; j++) begin
      idx = int'(beat) * 32 + j;
      if (idx < 4)
        d[255-8*j -: 8] = seq[31-8*idx -: 8];
      else if (idx < PKT_BYTES)
        d[255-8*j -: 8] = 8'(idx);
    end
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq   <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= '0;
      r_empty <= '0;
`ifdef ST_PACKET_GENERATOR_IDLE_GAP_EN
      r_gap   <= '0;
`endif
    end else begin
      if (w_xfer) begin
        r_seq  <= w_pos_seq;
        r_beat <= w_pos_beat;
      end
`ifdef ST_PACKET_GENERATOR_IDLE_GAP_EN
      if (w_xfer && r_eop && IDLE_CYCLES > 0) begin
        // The cycle after the eop transfer is the first gap cycle.
        r_valid <= 1'b0;
        r_gap   <= 16'(IDLE_CYCLES - 1);
      end else if (!r_valid && r_gap != '0) begin
        r_gap   <= r_gap - 16'd1;
      end else
`endif
      if (w_xfer || !r_valid) begin
        r_valid <= 1'b1;
        r_sop   <= (w_pos_beat == '0);
        r_eop   <= w_pos_eop;
        r_empty <= w_pos_eop ? EMPTY : 5'd0;
        r_data  <= beat_data(w_pos_seq, w_pos_beat);
      end
    end
  end

  assign st_out.channel       = 4'(CHANNEL);
  assign st_out.valid         = r_valid;
  assign st_out.startofpacket = r_sop;
  assign st_out.endofpacket   = r_eop;
  assign st_out.data          = r_data;
  assign st_out.empty         = r_empty;
endmodule

// File: tb/tb_st_packet_generator.sv
// tb/tb_st_packet_generator.sv - directed table plus corner sequences for st_packet_generator.
module tb_st_packet_generator;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  st_packet_generator_if u_if ();
  st_packet_generator_if u_if32 ();
  st_packet_generator_if u_if33 ();

  st_packet_generator #(.CHANNEL(0), .PKT_BYTES(100), .IDLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .st_out(u_if));
  st_packet_generator #(.CHANNEL(0), .PKT_BYTES(32), .IDLE_CYCLES(4)) dut32 (
    .clk(clk), .reset(reset), .st_out(u_if32));
  st_packet_generator #(.CHANNEL(0), .PKT_BYTES(33), .IDLE_CYCLES(4)) dut33 (
    .clk(clk), .reset(reset), .st_out(u_if33));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] m_data(input int pkt, input int seq, input int beat);
    logic [255:0] d;
    logic [31:0]  s;
    logic [7:0]   bv;
    int           i;
    d = '0;
    s = 32'(seq);
    for (int j = 0; j < 32; j++) begin
      i = beat * 32 + j;
      if (i < 4)        bv = 8'(s >> (24 - 8 * i));
      else if (i < pkt) bv = 8'(i);
      else              bv = 8'h00;
      d = d | (256'(bv) << (8 * (31 - j)));
    end
    return d;
  endfunction

  task automatic chk_beat(input string tag, input int pkt, input int seq, input int beat,
                          input logic v, input logic sop, input logic eop,
                          input logic [4:0] emp, input logic [255:0] d);
    int nb;
    int e_emp;
    nb    = (pkt + 31) / 32;
    e_emp = (beat == nb - 1) ? nb * 32 - pkt : 0;
    check({tag, ".valid"}, 256'(v), 256'(1));
    check({tag, ".sop"}, 256'(sop), 256'(beat == 0));
    check({tag, ".eop"}, 256'(eop), 256'(beat == nb - 1));
    check({tag, ".empty"}, 256'(emp), 256'(e_emp));
    check({tag, ".data"}, d, m_data(pkt, seq, beat));
  endtask

  task automatic chk_main(input string tag, input int seq, input int beat);
    chk_beat(tag, 100, seq, beat, u_if.valid, u_if.startofpacket, u_if.endofpacket,
             u_if.empty, u_if.data);
  endtask

  typedef struct {
    logic       rdy;
    int         seq;
    int         beat;
    logic       sop;
    logic       eop;
    logic [4:0] empty;
  } vec_t;

  vec_t tbl[13];
  int   es, eb;
  logic r;
  logic [31:0] w32;

  initial begin
    tbl[0]  = '{1'b1, 0, 0, 1'b1, 1'b0, 5'd0};
    tbl[1]  = '{1'b1, 0, 1, 1'b0, 1'b0, 5'd0};
    tbl[2]  = '{1'b1, 0, 2, 1'b0, 1'b0, 5'd0};
    tbl[3]  = '{1'b1, 0, 3, 1'b0, 1'b1, 5'd28};
    tbl[4]  = '{1'b1, 1, 0, 1'b1, 1'b0, 5'd0};
    tbl[5]  = '{1'b0, 1, 1, 1'b0, 1'b0, 5'd0};
    tbl[6]  = '{1'b0, 1, 1, 1'b0, 1'b0, 5'd0};
    tbl[7]  = '{1'b1, 1, 1, 1'b0, 1'b0, 5'd0};
    tbl[8]  = '{1'b1, 1, 2, 1'b0, 1'b0, 5'd0};
    tbl[9]  = '{1'b0, 1, 3, 1'b0, 1'b1, 5'd28};
    tbl[10] = '{1'b1, 1, 3, 1'b0, 1'b1, 5'd28};
    tbl[11] = '{1'b1, 2, 0, 1'b1, 1'b0, 5'd0};
    tbl[12] = '{1'b0, 2, 1, 1'b0, 1'b0, 5'd0};

    reset = 1'b1;
    u_if.ready   = 1'b0;
    u_if32.ready = 1'b1;
    u_if33.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.valid", 256'(u_if.valid), 256'(0));
    check("rst.sop", 256'(u_if.startofpacket), 256'(0));
    check("rst.eop", 256'(u_if.endofpacket), 256'(0));
    check("rst.data", u_if.data, 256'(0));
    check("rst.empty", 256'(u_if.empty), 256'(0));
    check("rst.channel", 256'(u_if.channel), 256'(0));

`ifdef ST_PACKET_GENERATOR_IDLE_GAP_EN
    reset = 1'b0;
    u_if.ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        chk_main("gap_beat", p, b);
      end
      for (int g = 0; g < 4; g++) begin
        @(negedge clk);
        check("gap_valid", 256'(u_if.valid), 256'(0));
      end
    end
`else
    reset = 1'b0;
    u_if.ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check("tbl.valid", 256'(u_if.valid), 256'(1));
      check("tbl.sop", 256'(u_if.startofpacket), 256'(tbl[i].sop));
      check("tbl.eop", 256'(u_if.endofpacket), 256'(tbl[i].eop));
      check("tbl.empty", 256'(u_if.empty), 256'(tbl[i].empty));
      check("tbl.data", u_if.data, m_data(100, tbl[i].seq, tbl[i].beat));
      check("tbl.channel", 256'(u_if.channel), 256'(0));
      if (i == 0) begin
        w32 = u_if.data[255:224];
        check("first.seq", 256'(w32), 256'(32'h0000_0000));
        check("first.byte4", 256'(u_if.data[223:216]), 256'(8'h04));
      end
      if (i == 3) begin
        w32 = u_if.data[255:224];
        check("eop.bytes96_99", 256'(w32), 256'(32'h6061_6263));
        check("eop.tail_zero", 256'(u_if.data[223:0]), 256'(0));
      end
      u_if.ready = tbl[i].rdy;
    end

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_main("stall", 2, 1);
    end
    u_if.ready = 1'b1;
    @(negedge clk);
    chk_main("unstall_b2", 2, 2);
    @(negedge clk);
    chk_main("unstall_b3", 2, 3);

    es = 3;
    eb = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      chk_main("rand", es, eb);
      r = 1'($urandom_range(0, 1));
      u_if.ready = r;
      if (r) begin
        eb++;
        if (eb == 4) begin
          eb = 0;
          es++;
        end
      end
    end

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    u_if.ready = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      chk_main("run", k / 4, k % 4);
      chk_beat("p32", 32, k, 0, u_if32.valid, u_if32.startofpacket, u_if32.endofpacket,
               u_if32.empty, u_if32.data);
      chk_beat("p33", 33, k / 2, k % 2, u_if33.valid, u_if33.startofpacket,
               u_if33.endofpacket, u_if33.empty, u_if33.data);
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst.valid", 256'(u_if.valid), 256'(0));
    check("midrst.sop", 256'(u_if.startofpacket), 256'(0));
    reset = 1'b0;
    @(negedge clk);
    chk_main("after_rst", 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
